// File: rtl/decoder_2x4_stream_if.sv
// Handshake bundle for the streaming binary-to-one-hot decoder.
// The slave side is the decoder; the master side drives codes and consumes one-hot words.
interface decoder_2x4_stream_if #(
    parameter int CODE_W = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) ();
    localparam int OH_W  = 1 << CODE_W;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;
    logic [OH_W-1:0]   out_onehot;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic [LVL_W-1:0]  level;

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out_onehot, out_valid, count, level
    );

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out_onehot, out_valid, count, level
    );
endinterface

// File: rtl/decoder_2x4_stream.sv
// Decodes accepted binary codes to one-hot words and queues them in a DEPTH-entry FIFO.
// First-word latency is one cycle; in_ready depends only on registered occupancy.
module decoder_2x4_stream #(
    parameter int CODE_W = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst,
    decoder_2x4_stream_if.slave bus
);
    localparam int OH_W  = 1 << CODE_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [OH_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready, out_valid, accept, pop;

    assign in_ready  = level_q < LVL_W'(DEPTH);
    assign out_valid = level_q != '0;
    assign accept    = bus.in_valid & in_ready;
    assign pop       = bus.out_ready & out_valid;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    // Masking keeps stale or never-written storage off the output.
    assign bus.out_onehot = out_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.count      = count_q;
    assign bus.level      = level_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_ptr_q] <= OH_W'(1) << bus.in_code;
        end
    end
endmodule
